// File: rtl/conv_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_fifo
// Purpose  : FWFT result FIFO behind the ZM->U2 converter, tags each word with
//            its error flag and keeps a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module conv_result_fifo #(
    parameter int BITS     = 32,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 8,
    parameter int DROP_ERR = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [BITS-1:0]            i_data,
    input  logic                       i_error,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [BITS-1:0]            o_data,
    output logic                       o_error,
    input  logic                       i_ready,
    input  logic                       i_clr_cnt,
    output logic [CNT_W-1:0]           o_err_count,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int               c_ADDR_W   = $clog2(DEPTH);
    localparam int               c_LVL_W    = c_ADDR_W + 1;
    localparam logic             c_KEEP_ERR = (DROP_ERR == 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    // Each entry is {error_tag, payload}
    logic [BITS:0]          r_mem [DEPTH];
    logic [c_ADDR_W-1:0]    r_wr_ptr;
    logic [c_ADDR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]     r_level;
    logic [CNT_W-1:0]       r_err_cnt;

    logic                   w_push;
    logic                   w_store;
    logic                   w_pop;
    logic [BITS:0]          w_head;

    assign o_ready = (r_level != c_LVL_W'(DEPTH));
    assign o_valid = (r_level != '0);

    assign w_push  = i_valid & o_ready;
    // A dropped errored word still completes the handshake; it only skips storage
    assign w_store = w_push & (~i_error | c_KEEP_ERR);
    assign w_pop   = o_valid & i_ready;

    assign w_head  = r_mem[r_rd_ptr];
    assign o_data  = o_valid ? w_head[BITS-1:0] : '0;
    assign o_error = o_valid ? w_head[BITS] : 1'b0;

    assign o_level     = r_level;
    assign o_err_count = r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {i_error, i_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Clear beats a concurrent increment; the counter sticks at its maximum
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_push && i_error && (r_err_cnt != c_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_result_fifo
// Purpose  : Directed bench for conv_result_fifo, one instance storing errored
//            words and one dropping them, checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_result_fifo;

    localparam int BITS  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            in_error;
    logic            in_ready;
    logic            clr_cnt;

    logic             ordy [2];
    logic             ov   [2];
    logic [BITS-1:0]  od   [2];
    logic             oe   [2];
    logic [CNT_W-1:0] ocnt [2];
    logic [LVL_W-1:0] olvl [2];

    conv_result_fifo #(.BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_ERR(0)) u_keep (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_data(in_data), .i_error(in_error),
        .o_ready(ordy[0]), .o_valid(ov[0]), .o_data(od[0]), .o_error(oe[0]),
        .i_ready(in_ready), .i_clr_cnt(clr_cnt), .o_err_count(ocnt[0]), .o_level(olvl[0])
    );

    conv_result_fifo #(.BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_ERR(1)) u_drop (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_data(in_data), .i_error(in_error),
        .o_ready(ordy[1]), .o_valid(ov[1]), .o_data(od[1]), .o_error(oe[1]),
        .i_ready(in_ready), .i_clr_cnt(clr_cnt), .o_err_count(ocnt[1]), .o_level(olvl[1])
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: instance 0 keeps errored words, instance 1 drops them
    logic [BITS:0] mq [2][$];
    int            mcnt [2];
    bit            live = 1'b0;

    always @(posedge clk) begin
        bit m_rdy, m_vld, m_push, m_pop;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                mcnt[k] = 0;
            end
            live = 1'b1;
        end else if (live) begin
            for (int k = 0; k < 2; k++) begin
                m_rdy  = (mq[k].size() != DEPTH);
                m_vld  = (mq[k].size() != 0);
                m_push = in_valid && m_rdy;
                m_pop  = m_vld && in_ready;
                if (m_pop) void'(mq[k].pop_front());
                if (m_push && !(in_error && k == 1)) mq[k].push_back({in_error, in_data});
                if (clr_cnt) mcnt[k] = 0;
                else if (m_push && in_error && mcnt[k] < (2**CNT_W - 1)) mcnt[k]++;
            end
        end
    end

    always @(negedge clk) begin
        logic [BITS:0] head;
        if (live) begin
            for (int k = 0; k < 2; k++) begin
                head = (mq[k].size() != 0) ? mq[k][0] : '0;
                check($sformatf("m%0d.valid", k), 64'(ov[k]),   64'(mq[k].size() != 0));
                check($sformatf("m%0d.ready", k), 64'(ordy[k]), 64'(mq[k].size() != DEPTH));
                check($sformatf("m%0d.level", k), 64'(olvl[k]), 64'(mq[k].size()));
                check($sformatf("m%0d.data", k),  64'(od[k]),   64'(head[BITS-1:0]));
                check($sformatf("m%0d.error", k), 64'(oe[k]),   64'(head[BITS]));
                check($sformatf("m%0d.count", k), 64'(ocnt[k]), 64'(mcnt[k]));
            end
        end
    end

    // Inputs apply to the next rising edge; returns just after that edge
    task automatic drive(input logic v, input logic [BITS-1:0] d, input logic e,
                         input logic r, input logic c);
        in_valid = v; in_data = d; in_error = e; in_ready = r; clr_cnt = c;
        @(posedge clk); #2;
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    logic [BITS-1:0] exp_seq [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_error = 1'b0;
        in_ready = 1'b0; clr_cnt = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        check("rst.valid", 64'(ov[0]), 64'd0);
        check("rst.ready", 64'(ordy[0]), 64'd1);
        check("rst.level", 64'(olvl[0]), 64'd0);
        check("rst.count", 64'(ocnt[0]), 64'd0);
        check("rst.data",  64'(od[0]), 64'd0);

        // Three words buffered, then drained in order one per cycle
        drive(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0; in_ready = 1'b1;
        @(negedge clk);
        check("fill3.level", 64'(olvl[0]), 64'd3);
        exp_seq[0] = 32'h0000_0005; exp_seq[1] = 32'hFFFF_FFFB; exp_seq[2] = 32'h7FFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            check($sformatf("drain3.data%0d", i), 64'(od[0]), 64'(exp_seq[i]));
            check($sformatf("drain3.err%0d", i),  64'(oe[0]), 64'd0);
            step();
        end
        @(negedge clk);
        check("drain3.empty", 64'(ov[0]), 64'd0);
        in_ready = 1'b0;

        // Overfill: fifth word held until a pop frees a slot
        for (int w = 1; w <= 4; w++) drive(1'b1, BITS'(w), 1'b0, 1'b0, 1'b0);
        in_data = 32'd5;
        @(negedge clk);
        check("full.ready", 64'(ordy[0]), 64'd0);
        check("full.level", 64'(olvl[0]), 64'd4);
        step();
        @(negedge clk);
        check("full.head", 64'(od[0]), 64'd1);
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        @(negedge clk);
        check("full.popref.level", 64'(olvl[0]), 64'd3);
        check("full.popref.head",  64'(od[0]), 64'd2);
        step();
        in_valid = 1'b0; in_ready = 1'b1;
        exp_seq[0] = 32'd2; exp_seq[1] = 32'd3; exp_seq[2] = 32'd4; exp_seq[3] = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("full.drain%0d", i), 64'(od[0]), 64'(exp_seq[i]));
            step();
        end
        in_ready = 1'b0;

        // Single errored word: stored with tag vs. dropped, both counted
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("err.keep.valid", 64'(ov[0]), 64'd1);
        check("err.keep.tag",   64'(oe[0]), 64'd1);
        check("err.keep.data",  64'(od[0]), 64'hDEAD_BEEF);
        check("err.keep.count", 64'(ocnt[0]), 64'd1);
        check("err.drop.level", 64'(olvl[1]), 64'd0);
        check("err.drop.count", 64'(ocnt[1]), 64'd1);
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;

        // Counter saturation, then clear beating a concurrent errored push
        for (int i = 0; i < 300; i++) drive(1'b1, BITS'(i), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("sat.keep", 64'(ocnt[0]), 64'd255);
        check("sat.drop", 64'(ocnt[1]), 64'd255);
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        check("clr.keep", 64'(ocnt[0]), 64'd0);
        check("clr.drop", 64'(ocnt[1]), 64'd0);
        step();
        in_ready = 1'b0;

        // Reset mid-stream with traffic on both sides
        drive(1'b1, 32'h0000_0011, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst.level", 64'(olvl[0]), 64'd2);
        check("pre_rst.count", 64'(ocnt[0]), 64'd2);
        rst = 1'b1; in_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        @(negedge clk);
        check("mid_rst.level", 64'(olvl[0]), 64'd0);
        check("mid_rst.valid", 64'(ov[0]), 64'd0);
        check("mid_rst.count", 64'(ocnt[0]), 64'd0);
        check("mid_rst.data",  64'(od[0]), 64'd0);
        check("mid_rst.drop.count", 64'(ocnt[1]), 64'd0);
        step();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_result_fifo.md
Name: conv_result_fifo

Overview:
- Registered output stage directly downstream of the combinational ZM→U2 converter.
- Captures each converted word (`o_result`) together with its conversion error flag (`o_error`) into a small first-word-fall-through FIFO.
- Uses a valid/ready handshake on both sides.
- Keeps a saturating error counter, so the synchronous arithmetic unit can drain results at its own pace and report bad inputs (negative zero).

Parameters:
- BITS, 32, data width; matches the converter width.
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- CNT_W, 8, width of the error counter.
- DROP_ERR, 0, 0 = store errored words with their error tag; 1 = discard errored words (counted only).

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- i_data  input  BITS  converted U2 word from the converter.
- i_error  input  1  converter error flag for i_data.
- o_ready  output  1  FIFO can accept a word this cycle.
- o_valid  output  1  head entry valid.
- o_data  output  BITS  head entry data.
- o_error  output  1  head entry error tag.
- i_ready  input  1  downstream accepts head this cycle.
- i_clr_cnt  input  1  synchronous clear of error counter.
- o_err_count  output  CNT_W  saturating count of accepted errored words.
- o_level  output  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Reset (i_rst=1 at clock edge) overrides everything and discards any in-flight data. It sets:
  - write and read pointers, o_level, o_err_count to 0.
  - o_valid=0, o_ready=1 (from the first cycle after reset).
- Accept: push_hs = i_valid & o_ready.
  - push_hs with i_error=0 stores {i_error, i_data}.
  - push_hs with i_error=1 stores only if DROP_ERR=0; with DROP_ERR=1 the handshake completes but nothing is written.
- Pop: pop_hs = o_valid & i_ready; advances read pointer.
- o_ready = (o_level != DEPTH). It depends only on registered state and never on i_ready in the same cycle.
  - When full, a push is refused even if a pop occurs in the same cycle.
- o_valid = (o_level != 0).
  - o_data and o_error present the head entry combinationally from storage (FWFT).
  - When empty, o_data = 0 and o_error = 0.
- Latency: a word pushed at edge N is visible on o_valid/o_data after edge N (usable in cycle N+1). There is no same-cycle bypass when empty.
- Simultaneous push and pop (not full, not empty): both pointers advance and o_level is unchanged.
- Pointers wrap modulo DEPTH. o_level is an explicit counter: +1 on store only, −1 on pop only, unchanged on both or neither.
- Error counter:
  - Increments on every push_hs with i_error=1, independent of DROP_ERR.
  - Saturates at 2^CNT_W−1 and never wraps.
  - i_clr_cnt=1 sets it to 0 and wins over a concurrent increment; that error is not counted.
- Data is passed bit-exact, with no arithmetic on the payload.
- Inputs are sampled only on handshake. i_data/i_error are don't-care when i_valid=0.
- The outputs are stable while o_valid=1 and i_ready=0.

Test Plan:
- Reset then idle → o_valid=0, o_ready=1, o_level=0, o_err_count=0, o_data=0.
- Push 0x00000005, 0xFFFFFFFB, 0x7FFFFFFF with i_ready=0 → o_level=3. Then i_ready=1 → pops in order 5, 0xFFFFFFFB, 0x7FFFFFFF with o_error=0, one word per cycle.
- Push 5 words, DEPTH=4, i_ready=0 → o_ready=0 after the 4th. The 5th is held by upstream and accepted only after one pop. Verify no overwrite.
- DROP_ERR=0, push i_data=0xXXXXXXXX with i_error=1 → head shows o_error=1, o_err_count=1. Same with DROP_ERR=1 → o_level stays 0, o_err_count=1.
- Hold i_valid=1, i_error=1 for 300 cycles, CNT_W=8, DROP_ERR=1 → o_err_count saturates at 255. Then i_clr_cnt together with an errored push → count=0.
- Fill to 2 entries, assert i_rst mid-stream with i_valid=1 and i_ready=1 → next cycle o_level=0, o_valid=0, o_err_count=0, and no word is emitted.
